interface_hcsr04_bcd: RTL and testbench

//  Upstream measurement stage for the serial-output datapath: drives an HC-SR04 ultrasonic sensor and produces a
//  3-digit BCD distance in cm. Output medida[11:0] (hundreds/tens/units) feeds the 12-bit 'dados' input of the

---
 rtl/interface_hcsr04_bcd_pkg.sv | 14 +
 rtl/interface_hcsr04_bcd_contador.sv | 16 +
 rtl/interface_hcsr04_bcd.sv | 75 +++++++
 tb/tb_interface_hcsr04_bcd.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/interface_hcsr04_bcd_pkg.sv
// interface_hcsr04_bcd_pkg: FSM state codes and BCD limit shared by the HC-SR04 interface
package interface_hcsr04_bcd_pkg;
  typedef enum logic [2:0] {
    INICIAL       = 3'd0,
    PREPARA       = 3'd1,
    ENVIA_TRIGGER = 3'd2,
    ESPERA_ECHO   = 3'd3,
    MEDINDO       = 3'd4,
    ARMAZENA      = 3'd5,
    ERRO          = 3'd6,
    FINAL         = 3'd7
  } estado_t;
  localparam logic [11:0] BCD_MAX = 12'h999;
endpackage

// File: rtl/interface_hcsr04_bcd_contador.sv
// contador_bcd_3dig: 3-digit BCD up-counter with synchronous clear, saturating at 999
module contador_bcd_3dig
  import interface_hcsr04_bcd_pkg::*;
(
  input  logic        clock,
  input  logic        zera_s,
  input  logic        conta,
  output logic [11:0] bcd
);
  always_ff @(posedge clock)
    if (zera_s) bcd <= '0;
    else if (conta && bcd != BCD_MAX)
      bcd <= bcd[3:0] != 4'd9 ? bcd + 12'd1 :
             bcd[7:4] != 4'd9 ? {bcd[11:8], bcd[7:4] + 4'd1, 4'd0} :
                                {bcd[11:8] + 4'd1, 8'd0};
endmodule

// File: rtl/interface_hcsr04_bcd.sv
// interface_hcsr04_bcd: HC-SR04 trigger/echo controller producing a 3-digit BCD distance in cm
module interface_hcsr04_bcd
  import interface_hcsr04_bcd_pkg::*;
#(
  parameter int TRIGGER_CICLOS = 500,
  parameter int CICLOS_CM      = 2941,
  parameter int TIMEOUT_CICLOS = 2_500_000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        medir,
  input  logic        echo,
  output logic        trigger,
  output logic [11:0] medida,
  output logic        pronto,
  output logic        erro,
  output logic [3:0]  db_estado
);
  localparam int CW = $clog2(TRIGGER_CICLOS > CICLOS_CM ? TRIGGER_CICLOS : CICLOS_CM);
  localparam int TW = $clog2(TIMEOUT_CICLOS + 1);
  estado_t estado, proximo;
  logic e1, echo_s, mede, fim_trigger, fim_cm, timeout;
  logic [CW-1:0] cnt;
  logic [TW-1:0] tmo;
  logic [11:0] bcd;
  // The echo-high cycle that moves ESPERA_ECHO to MEDINDO is counted too, so width N yields floor(N/CICLOS_CM)
  assign mede = echo_s && (estado == ESPERA_ECHO || estado == MEDINDO);
  assign fim_trigger = cnt == CW'(TRIGGER_CICLOS - 1);
  assign fim_cm = cnt == CW'(CICLOS_CM - 1);
  // Timeout is acted on the cycle after the counter reaches TIMEOUT_CICLOS-1
  assign timeout = tmo == TW'(TIMEOUT_CICLOS);
  assign trigger = estado == ENVIA_TRIGGER;
  assign pronto = estado == FINAL;
  assign db_estado = {1'b0, estado};
  contador_bcd_3dig u_bcd (
    .clock (clock),
    .zera_s(reset || estado == PREPARA),
    .conta (mede && fim_cm),
    .bcd   (bcd)
  );
  always_ff @(posedge clock)
    if (reset) begin
      estado <= INICIAL;
      e1 <= 1'b0;
      echo_s <= 1'b0;
      cnt <= '0;
      tmo <= '0;
      medida <= '0;
      erro <= 1'b0;
    end else begin
      estado <= proximo;
      e1 <= echo;
      echo_s <= e1;
      cnt <= estado == PREPARA ? '0 :
             estado == ENVIA_TRIGGER ? (fim_trigger ? '0 : cnt + CW'(1)) :
             mede ? (fim_cm ? '0 : cnt + CW'(1)) : cnt;
      tmo <= estado == PREPARA ? '0 :
             (estado == ESPERA_ECHO || estado == MEDINDO) ? tmo + TW'(1) : tmo;
      erro <= estado == PREPARA ? 1'b0 : estado == ERRO ? 1'b1 : erro;
      medida <= estado == ARMAZENA ? bcd : estado == ERRO ? BCD_MAX : medida;
    end
  always_comb begin
    proximo = estado;
    case (estado)
      INICIAL:       proximo = medir ? PREPARA : INICIAL;
      PREPARA:       proximo = ENVIA_TRIGGER;
      ENVIA_TRIGGER: proximo = fim_trigger ? ESPERA_ECHO : ENVIA_TRIGGER;
      ESPERA_ECHO:   proximo = timeout ? ERRO : echo_s ? MEDINDO : ESPERA_ECHO;
      MEDINDO:       proximo = timeout ? ERRO : echo_s ? MEDINDO : ARMAZENA;
      ARMAZENA:      proximo = FINAL;
      ERRO:          proximo = FINAL;
      default:       proximo = INICIAL;
    endcase
  end
endmodule

// File: tb/tb_interface_hcsr04_bcd.sv
// tb_interface_hcsr04_bcd: scenario tasks with a scoreboard of {medida, erro} popped on every pronto
module tb_interface_hcsr04_bcd;
  localparam int T = 5;
  localparam int C = 4;
  localparam int TO = 5000;
  logic clock = 1'b0, reset, medir, echo, trigger, pronto, erro;
  logic [11:0] medida;
  logic [3:0] db_estado;
  logic [12:0] sb[$];
  logic [12:0] exp_v;
  int checks = 0, errors = 0, n_pronto = 0;

  interface_hcsr04_bcd #(.TRIGGER_CICLOS(T), .CICLOS_CM(C), .TIMEOUT_CICLOS(TO)) dut (
    .clock(clock), .reset(reset), .medir(medir), .echo(echo), .trigger(trigger),
    .medida(medida), .pronto(pronto), .erro(erro), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  always @(negedge clock)
    if (pronto) begin
      n_pronto++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pronto medida=%h erro=%b expected no pronto", medida, erro);
      end else begin
        exp_v = sb.pop_front();
        if ({medida, erro} !== exp_v) begin
          errors++;
          $display("FAIL scoreboard medida=%h erro=%b expected medida=%h erro=%b",
                   medida, erro, exp_v[12:1], exp_v[0]);
        end
      end
    end

  task automatic do_medir(output int tw);
    tw = 0;
    @(negedge clock) medir = 1'b1;
    @(negedge clock) medir = 1'b0;
    for (int i = 0; i < 100 && !trigger; i++) @(negedge clock);
    while (trigger && tw < 1000) begin
      tw++;
      @(negedge clock);
    end
  endtask

  task automatic do_echo(input int gap, input int width);
    repeat (gap) @(negedge clock);
    echo = 1'b1;
    repeat (width) @(negedge clock);
    echo = 1'b0;
  endtask

  task automatic wait_pronto(input int limit, output int cyc);
    cyc = 0;
    while (!pronto && cyc < limit) begin
      @(negedge clock);
      cyc++;
    end
    if (!pronto) cyc = -1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    medir = 1'b0;
    echo = 1'b0;
    repeat (3) @(negedge clock);
    checks += 4;
    if (medida !== 12'h000) begin errors++; $display("FAIL reset_medida got %h want 000", medida); end
    if (pronto !== 1'b0) begin errors++; $display("FAIL reset_pronto got %b want 0", pronto); end
    if (trigger !== 1'b0) begin errors++; $display("FAIL reset_trigger got %b want 0", trigger); end
    if (db_estado !== 4'd0) begin errors++; $display("FAIL reset_estado got %0d want 0", db_estado); end
    reset = 1'b0;
  endtask

  task automatic test_basic;
    int tw, cyc;
    sb.push_back({12'h100, 1'b0});
    do_medir(tw);
    checks++;
    if (tw !== T) begin errors++; $display("FAIL trigger_width got %0d want %0d", tw, T); end
    do_echo(3, 100 * C);
    wait_pronto(50, cyc);
    checks++;
    if (cyc !== 4) begin errors++; $display("FAIL pronto_latency got %0d want 4", cyc); end
    @(negedge clock);
    checks += 2;
    if (pronto !== 1'b0) begin errors++; $display("FAIL pronto_single got %b want 0", pronto); end
    if (db_estado !== 4'd0) begin errors++; $display("FAIL back_to_inicial got %0d want 0", db_estado); end
  endtask

  task automatic test_truncate_saturate;
    int tw, cyc;
    sb.push_back({12'h037, 1'b0});
    do_medir(tw);
    do_echo(2, 37 * C + C - 1);
    wait_pronto(50, cyc);
    checks++;
    if (cyc < 0) begin errors++; $display("FAIL truncate_done got timeout want pronto"); end
    @(negedge clock);
    sb.push_back({12'h999, 1'b0});
    do_medir(tw);
    do_echo(2, 1000 * C);
    wait_pronto(50, cyc);
    checks++;
    if (cyc < 0) begin errors++; $display("FAIL saturate_done got timeout want pronto"); end
    @(negedge clock);
  endtask

  task automatic test_timeout;
    int tw, cyc;
    sb.push_back({12'h999, 1'b1});
    do_medir(tw);
    wait_pronto(TO + 100, cyc);
    checks++;
    if (cyc !== TO + 2) begin errors++; $display("FAIL timeout_latency got %0d want %0d", cyc, TO + 2); end
    repeat (5) @(negedge clock);
    checks++;
    if (erro !== 1'b1) begin errors++; $display("FAIL erro_held got %b want 1", erro); end
    sb.push_back({12'h005, 1'b0});
    do_medir(tw);
    checks++;
    if (erro !== 1'b0) begin errors++; $display("FAIL erro_cleared got %b want 0", erro); end
    do_echo(2, 5 * C + 1);
    wait_pronto(50, cyc);
    @(negedge clock);
  endtask

  task automatic test_medir_ignored;
    int tw, cyc, n0;
    n0 = n_pronto;
    sb.push_back({12'h012, 1'b0});
    do_medir(tw);
    echo = 1'b1;
    repeat (5) @(negedge clock);
    medir = 1'b1;
    @(negedge clock) medir = 1'b0;
    repeat (12 * C - 6) @(negedge clock);
    echo = 1'b0;
    wait_pronto(50, cyc);
    repeat (20) @(negedge clock);
    checks += 2;
    if (n_pronto !== n0 + 1) begin errors++; $display("FAIL medir_ignored_prontos got %0d want %0d", n_pronto - n0, 1); end
    if (db_estado !== 4'd0) begin errors++; $display("FAIL medir_ignored_estado got %0d want 0", db_estado); end
  endtask

  task automatic test_reset_mid;
    int tw, n0;
    n0 = n_pronto;
    do_medir(tw);
    echo = 1'b1;
    repeat (20) @(negedge clock);
    checks++;
    if (db_estado !== 4'd4) begin errors++; $display("FAIL mid_medindo got %0d want 4", db_estado); end
    reset = 1'b1;
    @(negedge clock);
    checks += 3;
    if (db_estado !== 4'd0) begin errors++; $display("FAIL mid_reset_estado got %0d want 0", db_estado); end
    if (medida !== 12'h000) begin errors++; $display("FAIL mid_reset_medida got %h want 000", medida); end
    if (trigger !== 1'b0) begin errors++; $display("FAIL mid_reset_trigger got %b want 0", trigger); end
    reset = 1'b0;
    echo = 1'b0;
    repeat (20) @(negedge clock);
    checks++;
    if (n_pronto !== n0) begin errors++; $display("FAIL mid_reset_prontos got %0d want 0", n_pronto - n0); end
  endtask

  task automatic test_echo_ignored;
    int tw, cyc, n0;
    n0 = n_pronto;
    for (int i = 0; i < 10; i++) @(negedge clock) echo = ~echo;
    echo = 1'b0;
    repeat (5) @(negedge clock);
    checks += 2;
    if (db_estado !== 4'd0) begin errors++; $display("FAIL echo_inicial_estado got %0d want 0", db_estado); end
    if (n_pronto !== n0) begin errors++; $display("FAIL echo_inicial_prontos got %0d want 0", n_pronto - n0); end
    sb.push_back({12'h003, 1'b0});
    @(negedge clock) medir = 1'b1;
    @(negedge clock) medir = 1'b0;
    for (int i = 0; i < 100 && !trigger; i++) @(negedge clock);
    echo = 1'b1;
    @(negedge clock) echo = 1'b0;
    for (int i = 0; i < 100 && trigger; i++) @(negedge clock);
    repeat (3) @(negedge clock);
    checks++;
    if (db_estado !== 4'd3) begin errors++; $display("FAIL echo_trigger_estado got %0d want 3", db_estado); end
    do_echo(0, 3 * C);
    wait_pronto(50, cyc);
    @(negedge clock);
  endtask

  initial begin
    test_reset;
    test_basic;
    test_truncate_saturate;
    test_timeout;
    test_medir_ignored;
    test_reset_mid;
    test_echo_ignored;
    repeat (5) @(negedge clock);
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_drain got %0d pending want 0", sb.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
